// File: rtl/asyn_fifo_pkg.sv
// asyn_fifo shared defaults.
// Default geometry and pointer-width helper.
package asyn_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;

    // Pointer width needed to address a given depth.
    function automatic int calc_addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// asyn_fifo storage array.
// One write port, one registered read port.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage write; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read data, cleared by reset, held when idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/asyn_fifo.sv
// asyn_fifo: single-clock FIFO with full/empty and error pulses.
// Pointers, occupancy and flags live here; storage in fifo_mem.
module asyn_fifo
    import asyn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int ADDR_W = calc_addr_w(DEPTH);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_rd_ok;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_wr_ok = wen & ~w_full;
    assign w_rd_ok = ren & ~w_empty;

    // Write pointer advances on each accepted write.
    always_ff @(posedge wclk) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_wr_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // Read pointer advances on each accepted read.
    always_ff @(posedge wclk) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_rd_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy tracks net accepted writes minus reads.
    always_ff @(posedge wclk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Error pulses: one cycle per rejected request.
    always_ff @(posedge wclk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wen & w_full;
            r_underflow <= ren & w_empty;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .i_clk   (wclk),
        .i_rst   (rst),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr),
        .i_wdata (wdata),
        .i_re    (w_rd_ok),
        .i_raddr (r_rd_ptr),
        .o_rdata (rdata)
    );

    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_asyn_fifo.sv
// asyn_fifo testbench.
// Directed boundary cases plus random traffic against a queue model.
module tb_asyn_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 8;

    logic          wclk = 1'b0;
    logic          rst = 1'b0;
    logic          wen = 1'b0;
    logic          ren = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          underflow;

    int n_chk = 0;
    int n_pass = 0;

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rdata = '0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    asyn_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .wclk      (wclk),
        .rst       (rst),
        .wen       (wen),
        .ren       (ren),
        .wdata     (wdata),
        .rdata     (rdata),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // One clock: drive, advance model, compare all outputs.
    task automatic step(input logic r, input logic w, input logic rd,
                        input logic [DW-1:0] d);
        bit was_full;
        bit was_empty;
        rst = r;
        wen = w;
        ren = rd;
        wdata = d;
        @(posedge wclk);
        was_full = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (r) begin
            m_q.delete();
            m_rdata = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_ovf = w && was_full;
            m_udf = rd && was_empty;
            if (rd && !was_empty) m_rdata = m_q.pop_front();
            if (w && !was_full) m_q.push_back(d);
        end
        #1;
        chk("rdata", 32'(rdata), 32'(m_rdata));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
    endtask

    initial begin
        // Reset with requests asserted: nothing may be written.
        step(1, 1, 1, 8'h99);
        step(1, 1, 1, 8'h99);
        step(0, 0, 0, 8'h00);

        // Fill, overflow attempt, drain, underflow.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(8'h11 + i));
        step(0, 1, 0, 8'hAA);
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);

        // Simultaneous at full, then at empty.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'(8'h30 + i));
        step(0, 1, 1, 8'h77);
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, 8'h00);
        step(0, 1, 1, 8'h5C);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);

        // Interleaved pairs crossing the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 8'($urandom));
            step(0, 0, 1, 8'h00);
        end

        // Reset with entries stored, then read attempt.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'hC0 + i));
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 64) == 0, $urandom % 2 == 1,
                 $urandom % 2 == 1, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
